// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   Conditional-branch direction predictor for the 5-stage MIPS pipeline.
//   The Fetch-stage lookup reads a table of 2-bit saturating counters (PHT).
//   The prediction is registered into Decode as pred_takeD.
//   The table is trained from the Memory stage with the resolved outcome.
//   Optional feature macro: GSHARE_EN. When it is defined, a global history
//   register is XOR-folded into the index. When it is undefined, the
//   predictor is purely bimodal.
module gshare_branch_predictor #(
  parameter int PHT_BITS = 8,
  parameter int GHR_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcF,
  input  logic        branchM,
  input  logic [31:0] pcM,
  input  logic        actual_takeM,
  output logic        pred_takeD
);

  localparam int PHT_ENTRIES = 1 << PHT_BITS;

  // Counter encodings: the MSB is the predicted direction.
  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

  logic [1:0]          r_pht [PHT_ENTRIES];
  logic                r_pred_take;
  logic [PHT_BITS-1:0] w_idx_f;
  logic [PHT_BITS-1:0] w_idx_m;
  logic [1:0]          w_cnt_m;
  logic [1:0]          w_cnt_next;
  logic                w_pred_f;
  logic                w_unused_pc;

  // Only the word-index bits of each PC form the index. The rest alias away.
  assign w_unused_pc = ^{pcF, pcM};

`ifdef GSHARE_EN
  logic [GHR_BITS-1:0] r_ghr;
  logic [PHT_BITS-1:0] w_ghr_ext;

  // Zero-extend the history into the low index bits.
  assign w_ghr_ext = PHT_BITS'(r_ghr);
  assign w_idx_f   = pcF[PHT_BITS+1:2] ^ w_ghr_ext;
  assign w_idx_m   = pcM[PHT_BITS+1:2] ^ w_ghr_ext;

  // Non-speculative history: shift in retired branch outcomes only.
  // Both lookup and update in the same cycle see the pre-shift value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (branchM) begin
      r_ghr <= {r_ghr[GHR_BITS-2:0], actual_takeM};
    end
  end
`else
  assign w_idx_f = pcF[PHT_BITS+1:2];
  assign w_idx_m = pcM[PHT_BITS+1:2];
`endif

  // Fetch lookup reads the stored value, so a same-cycle update is not bypassed.
  assign w_pred_f = r_pht[w_idx_f][1];

  // Saturating increment or decrement of the counter being trained.
  assign w_cnt_m = r_pht[w_idx_m];
  always_comb begin
    w_cnt_next = w_cnt_m;
    if (actual_takeM) begin
      if (w_cnt_m != CNT_STRONG_T) w_cnt_next = w_cnt_m + 2'd1;
    end else begin
      if (w_cnt_m != CNT_STRONG_NT) w_cnt_next = w_cnt_m - 2'd1;
    end
  end

  // PHT training from the Memory stage; reset clears the whole table.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is flops, not RAM, because reset must return every
      // counter to weakly not-taken in one cycle. A RAM macro cannot do that.
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        r_pht[i] <= CNT_WEAK_NT;
      end
    end else if (branchM) begin
      r_pht[w_idx_m] <= w_cnt_next;
    end
  end

  // Decode prediction register. Priority order: reset, flush, stall, load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_take <= 1'b0;
    end else if (flushD) begin
      r_pred_take <= 1'b0;
    end else if (!stallD) begin
      r_pred_take <= w_pred_f;
    end
  end

  assign pred_takeD = r_pred_take;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor
//   Directed bench for gshare_branch_predictor.
//   Expected values are hand-computed from the counter and index rules.
//   With GSHARE_EN defined, the history-folding scenario runs instead of the
//   bimodal scenarios.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD;
  logic        flushD;
  logic [31:0] pcF;
  logic        branchM;
  logic [31:0] pcM;
  logic        actual_takeM;
  logic        pred_takeD;

  int checks = 0;
  int errors = 0;

  gshare_branch_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .stallD       (stallD),
    .flushD       (flushD),
    .pcF          (pcF),
    .branchM      (branchM),
    .pcM          (pcM),
    .actual_takeM (actual_takeM),
    .pred_takeD   (pred_takeD)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge. Outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One cycle of Memory-stage training, then deassert branchM.
  task automatic train(input logic [31:0] pc, input logic take);
    pcM          = pc;
    actual_takeM = take;
    branchM      = 1'b1;
    tick();
    branchM      = 1'b0;
  endtask

  // Present pc in Fetch for one cycle. Return the resulting Decode prediction.
  task automatic lookup(input logic [31:0] pc, output logic pred);
    pcF = pc;
    tick();
    pred = pred_takeD;
  endtask

  task automatic test_reset();
    logic p;
    do_reset();
    checks++;
    if (pred_takeD !== 1'b0) begin
      $display("FAIL reset_pred: got %b expected 0", pred_takeD);
      errors++;
    end
    lookup(32'h0000_0044, p);
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL reset_counter_01: got %b expected 0", p);
      errors++;
    end
  endtask

  task automatic test_train();
    logic p;
    pcF = 32'h0;
    train(32'h44, 1'b1);   // 01 -> 10
    train(32'h44, 1'b1);   // 10 -> 11
    lookup(32'h44, p);
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL train_0x44: got %b expected 1", p);
      errors++;
    end
    lookup(32'h444, p);    // index 0x111 truncates to 0x11
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL alias_0x444: got %b expected 1", p);
      errors++;
    end
    lookup(32'h48, p);     // neighbouring entry untouched
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL neighbour_0x48: got %b expected 0", p);
      errors++;
    end
  endtask

  task automatic test_saturation();
    logic p;
    for (int i = 0; i < 5; i++) train(32'h80, 1'b1);  // saturate at 11
    train(32'h80, 1'b0);                              // 11 -> 10
    lookup(32'h80, p);
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL hyst_one_nt: got %b expected 1", p);
      errors++;
    end
    train(32'h80, 1'b0);                              // 10 -> 01
    lookup(32'h80, p);
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL hyst_two_nt: got %b expected 0", p);
      errors++;
    end
    for (int i = 0; i < 3; i++) train(32'h80, 1'b0);  // floor at 00
    lookup(32'h80, p);
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL floor_pred: got %b expected 0", p);
      errors++;
    end
    train(32'h80, 1'b1);                              // 00 -> 01
    lookup(32'h80, p);
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL no_underflow_a: got %b expected 0", p);
      errors++;
    end
    train(32'h80, 1'b1);                              // 01 -> 10
    lookup(32'h80, p);
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL no_underflow_b: got %b expected 1", p);
      errors++;
    end
  endtask

  task automatic test_stall_flush();
    logic p;
    lookup(32'h44, p);     // entry 0x11 is 11
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL stall_setup: got %b expected 1", p);
      errors++;
    end
    stallD = 1'b1;
    lookup(32'h48, p);
    lookup(32'h48, p);
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL stall_hold: got %b expected 1", p);
      errors++;
    end
    flushD = 1'b1;         // flush wins over a simultaneous stall
    lookup(32'h44, p);
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL flush_over_stall: got %b expected 0", p);
      errors++;
    end
    stallD = 1'b0;
    flushD = 1'b0;
    lookup(32'h44, p);
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL reload_after_flush: got %b expected 1", p);
      errors++;
    end
    flushD = 1'b1;
    lookup(32'h44, p);
    flushD = 1'b0;
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL flush_alone: got %b expected 0", p);
      errors++;
    end
  endtask

  task automatic test_read_old();
    logic p;
    do_reset();            // entry 0x11 back to 01
    pcF          = 32'h44;
    pcM          = 32'h44;
    actual_takeM = 1'b1;
    branchM      = 1'b1;
    tick();
    branchM      = 1'b0;
    checks++;
    if (pred_takeD !== 1'b0) begin
      $display("FAIL read_old_same_cycle: got %b expected 0", pred_takeD);
      errors++;
    end
    lookup(32'h44, p);     // now 10
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL read_new_next_cycle: got %b expected 1", p);
      errors++;
    end
  endtask

  task automatic test_no_update();
    logic p;
    pcF          = 32'h0;
    pcM          = 32'h4C;
    actual_takeM = 1'b1;
    branchM      = 1'b0;
    repeat (3) tick();
    lookup(32'h4C, p);
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL branchM_low_ignored: got %b expected 0", p);
      errors++;
    end
  endtask

  task automatic test_gshare();
    logic p;
    do_reset();
    pcF = 32'h0;
    train(32'h100, 1'b1);  // PHT[0x40] -> 10, GHR -> 000001
    train(32'h100, 1'b1);  // PHT[0x41] -> 10, GHR -> 000011
    train(32'h44, 1'b1);   // PHT[0x12] -> 10, GHR -> 000111
    // With GHR = 0x07, a pc whose word index is x reads entry x^0x07.
    lookup(32'h54, p);     // 0x15 ^ 0x07 = 0x12
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL gshare_entry_0x12: got %b expected 1", p);
      errors++;
    end
    lookup(32'h58, p);     // 0x16 ^ 0x07 = 0x11, untouched
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL gshare_entry_0x11: got %b expected 0", p);
      errors++;
    end
    lookup(32'h44, p);     // 0x11 ^ 0x07 = 0x16, untouched
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL gshare_pc44_now: got %b expected 0", p);
      errors++;
    end
    lookup(32'h11C, p);    // 0x47 ^ 0x07 = 0x40
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL gshare_entry_0x40: got %b expected 1", p);
      errors++;
    end
    lookup(32'h118, p);    // 0x46 ^ 0x07 = 0x41
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL gshare_entry_0x41: got %b expected 1", p);
      errors++;
    end
  endtask

  initial begin
    rst          = 1'b0;
    stallD       = 1'b0;
    flushD       = 1'b0;
    pcF          = 32'h0;
    branchM      = 1'b0;
    pcM          = 32'h0;
    actual_takeM = 1'b0;
    #2;
    test_reset();
`ifdef GSHARE_EN
    test_gshare();
`else
    test_train();
    test_saturation();
    test_stall_flush();
    test_read_old();
    test_no_update();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
